regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with zero-latency reads, a scoreboard of
// pending destination registers, and a hardware clear sequence after reset.
//
// Parameters:
//   DATA_W - data width in bits
//   ADDR_W - register address width, DEPTH = 2**ADDR_W entries
//   NRD    - number of independent read ports (>= 1)
//
// Ports:
//   clk, rst       - clock (rising edge), synchronous active-high reset
//   re, raddr      - per-port read enable / address (port i at [i*ADDR_W +: ADDR_W])
//   rdata          - per-port read data (port i at [i*DATA_W +: DATA_W])
//   rbusy, stall   - per-port pending-write flag and OR of all of them
//   we/waddr/wdata - write-back port; also clears the scoreboard bit
//   issue_en/addr  - marks an issued instruction's destination as pending
//   ready          - high once the clear sequence has finished
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write-back
// data to matching read ports and suppress their busy flag.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    output logic                  stall,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  issue_en,
    input  logic [ADDR_W-1:0]     issue_addr,
    output logic                  ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    // Next-state logic. Reset takes priority and discards any write or issue
    // presented in the same cycle; the array itself is zeroed by INIT.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        mem_d     = mem_q;
        if (rst) begin
            state_d   = INIT;
            clr_cnt_d = '0;
            busy_d    = '0;
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    mem_d[clr_cnt_q] = '0;
                    clr_cnt_d        = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end
                RUN: begin
                    if (we && waddr != '0) begin
                        mem_d[waddr]  = wdata;
                        busy_d[waddr] = 1'b0;
                    end
                    // Applied after the clear so a same-cycle issue wins.
                    if (issue_en && issue_addr != '0) begin
                        busy_d[issue_addr] = 1'b1;
                    end
                end
                default: begin
                    state_d = INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_cnt_q <= clr_cnt_d;
        busy_q    <= busy_d;
        ready_q   <= ready_d;
        mem_q     <= mem_d;
    end

    assign ready = ready_q;

    // Combinational read ports; entry 0 and all INIT-time reads return zero.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (state_q == RUN && re[i] && raddr[i*ADDR_W +: ADDR_W] != '0) begin
                rdata[i*DATA_W +: DATA_W] = mem_q[raddr[i*ADDR_W +: ADDR_W]];
                rbusy[i]                  = busy_q[raddr[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
                if (we && waddr == raddr[i*ADDR_W +: ADDR_W]) begin
                    rdata[i*DATA_W +: DATA_W] = wdata;
                    rbusy[i]                  = 1'b0;
                end
`endif
            end
        end
    end

    assign stall = |rbusy;

endmodule
